// File: rtl/cordic_sched.sv
// Scheduler that arbitrates two angle requesters onto a single iterative CORDIC core
// and returns each result on a shared response channel.
module cordic_sched #(
    parameter int unsigned W    = 8,
    parameter int unsigned ITER = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_angle,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_angle,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_x,
    output logic [W-1:0] rsp_y,
    output logic         core_load,
    output logic         core_en,
    output logic [W-1:0] core_angle,
    input  logic [W-1:0] core_x,
    input  logic [W-1:0] core_y,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         rr_q, rr_d;
    logic         id_q, id_d;
    logic [W-1:0] ang_q, ang_d;
    logic [W-1:0] rx_q, rx_d;
    logic [W-1:0] ry_q, ry_d;
    logic         gnt0, gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            ang_q   <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            ang_q   <= ang_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

    // A lone valid requester always wins; rr only breaks ties.
    assign gnt0 = req0_valid & (~req1_valid | ~rr_q);
    assign gnt1 = req1_valid & (~req0_valid | rr_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        id_d       = id_q;
        ang_d      = ang_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        core_load  = 1'b0;
        core_en    = 1'b0;
        core_angle = '0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (gnt0 || gnt1) begin
                    state_d = LOAD;
                    id_d    = gnt1;
                    ang_d   = gnt1 ? req1_angle : req0_angle;
                end
            end
            LOAD: begin
                core_load  = 1'b1;
                core_angle = ang_q;
                cnt_d      = '0;
                state_d    = RUN;
            end
            RUN: begin
                core_en = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAPT: begin
                rx_d    = core_x;
                ry_d    = core_y;
                state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rr_d    = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides every register update above, so an abort leaves no trace.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            rr_d    = rr_q;
            id_d    = id_q;
            ang_d   = ang_q;
            rx_d    = rx_q;
            ry_d    = ry_q;
        end
    end

    assign rsp_id = id_q;
    assign rsp_x  = rx_q;
    assign rsp_y  = ry_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_sched.sv
// Directed-plus-random bench for cordic_sched against a job-level timing/arbitration model.
module tb_cordic_sched;

    localparam int W    = 8;
    localparam int ITER = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_angle = '0, req1_angle = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, rsp_ready = 1'b0;
    logic [W-1:0] rsp_x, rsp_y;
    logic         core_load, core_en, busy;
    logic [W-1:0] core_angle, core_x = '0, core_y = '0;

    logic         s_req0_valid = 1'b0, s_req1_valid = 1'b0;
    logic [W-1:0] s_req0_angle = '0, s_req1_angle = '0;
    logic         s_req0_ready, s_req1_ready;
    logic         s_rsp_valid, s_rsp_id, s_rsp_ready = 1'b1;
    logic [W-1:0] s_rsp_x, s_rsp_y;
    logic         s_core_load, s_core_en, s_busy;
    logic [W-1:0] s_core_angle, s_core_x = '0, s_core_y = '0;

    int n_checks = 0;
    int n_err    = 0;
    bit rr_m     = 1'b0;

    always #5 clk = ~clk;

    cordic_sched #(.W(W), .ITER(ITER)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y),
        .core_load(core_load), .core_en(core_en), .core_angle(core_angle),
        .core_x(core_x), .core_y(core_y), .busy(busy)
    );

    cordic_sched #(.W(W), .ITER(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req0_valid(s_req0_valid), .req0_angle(s_req0_angle), .req0_ready(s_req0_ready),
        .req1_valid(s_req1_valid), .req1_angle(s_req1_angle), .req1_ready(s_req1_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
        .rsp_x(s_rsp_x), .rsp_y(s_rsp_y),
        .core_load(s_core_load), .core_en(s_core_en), .core_angle(s_core_angle),
        .core_x(s_core_x), .core_y(s_core_y), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // abort: 0 = complete normally, 1 = flush at RUN counter 3, 2 = async reset during CAPT
    task automatic run_job(input bit v0, input bit v1, input logic [W-1:0] a0,
                           input int hold, input int abort);
        bit           g;
        logic [W-1:0] ang, rx, ry, px, py;
        logic [W-1:0] xs[64];
        logic [W-1:0] ys[64];
        int           t, n_load, n_en, first_en, last_en;
        req0_valid = v0;
        req1_valid = v1;
        req0_angle = a0;
        req1_angle = W'($urandom);
        g   = (v0 && v1) ? rr_m : !v0;
        ang = g ? req1_angle : req0_angle;
        core_x = W'($urandom);
        core_y = W'($urandom);
        #1;
        chk("grant0", 32'(req0_ready), 32'(!g));
        chk("grant1", 32'(req1_ready), 32'(g));
        chk("idle_busy", 32'(busy), 32'(0));
        px = rsp_x;
        py = rsp_y;
        @(posedge clk);
        t = 0; n_load = 0; n_en = 0; first_en = 0; last_en = 0;
        while (t < 40) begin
            @(negedge clk);
            t++;
            core_x = W'($urandom);
            core_y = W'($urandom);
            xs[t] = core_x;
            ys[t] = core_y;
            #1;
            chk("load_en_excl", 32'(core_load & core_en), 32'(0));
            chk("ready_busy", 32'(req0_ready | req1_ready), 32'(0));
            if (core_load) begin
                n_load++;
                chk("load_cycle", 32'(t), 32'(1));
                chk("core_angle", 32'(core_angle), 32'(ang));
            end else begin
                chk("angle_zero", 32'(core_angle), 32'(0));
            end
            if (core_en) begin
                if (n_en == 0) first_en = t;
                n_en++;
                last_en = t;
            end
            if (abort == 1 && t == 5) begin
                chk("flush_in_run", 32'(core_en), 32'(1));
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                #1;
                chk("flush_idle", 32'(busy), 32'(0));
                chk("flush_en", 32'(core_en), 32'(0));
                chk("flush_rsp", 32'(rsp_valid), 32'(0));
                chk("flush_x", 32'(rsp_x), 32'(px));
                chk("flush_y", 32'(rsp_y), 32'(py));
                repeat (3) @(negedge clk);
                #1;
                chk("flush_no_rsp", 32'(rsp_valid | busy), 32'(0));
                return;
            end
            if (abort == 2 && t == ITER + 2) begin
                #1;
                reset_n = 1'b0;
                #1;
                chk("rst_valid", 32'(rsp_valid), 32'(0));
                chk("rst_load", 32'(core_load), 32'(0));
                chk("rst_en", 32'(core_en), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_x", 32'(rsp_x), 32'(0));
                chk("rst_y", 32'(rsp_y), 32'(0));
                chk("rst_id", 32'(rsp_id), 32'(0));
                chk("rst_angle", 32'(core_angle), 32'(0));
                rr_m = 1'b0;
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (rsp_valid) break;
        end
        chk("latency", 32'(t), 32'(ITER + 3));
        if (t != ITER + 3) return;
        chk("n_load", 32'(n_load), 32'(1));
        chk("n_en", 32'(n_en), 32'(ITER));
        chk("en_contig", 32'(last_en - first_en + 1), 32'(ITER));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_x", 32'(rsp_x), 32'(xs[last_en + 1]));
        chk("rsp_y", 32'(rsp_y), 32'(ys[last_en + 1]));
        rx = rsp_x;
        ry = rsp_y;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            core_x = W'($urandom);
            core_y = W'($urandom);
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'(1));
            chk("hold_x", 32'(rsp_x), 32'(rx));
            chk("hold_y", 32'(rsp_y), 32'(ry));
            chk("hold_id", 32'(rsp_id), 32'(g));
            chk("hold_ready", 32'(req0_ready | req1_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        #1;
        chk("done_valid", 32'(rsp_valid), 32'(1));
        chk("done_no_accept", 32'(req0_ready | req1_ready), 32'(0));
        @(negedge clk);
        #1;
        chk("back_idle", 32'(busy), 32'(0));
        chk("rsp_drop", 32'(rsp_valid), 32'(0));
        rsp_ready  = 1'b0;
        rr_m       = !g;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           r, t, n;
        logic [W-1:0] sx[32];

        #2;
        chk("reset_valid", 32'(rsp_valid), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_load_en", 32'({core_load, core_en}), 32'(0));
        chk("reset_xy", 32'({rsp_x, rsp_y}), 32'(0));
        chk("reset_id", 32'(rsp_id), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_job(1'b1, 1'b0, 8'h20, 0, 0);
        run_job(1'b0, 1'b1, W'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) run_job(1'b1, 1'b1, W'($urandom), 0, 0);
        run_job(1'b0, 1'b1, W'($urandom), 5, 0);
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(1, 3);
            run_job(r[0], r[1], W'($urandom), $urandom_range(0, 3), 0);
        end
        run_job(1'b1, 1'b1, W'($urandom), 0, 1);
        run_job(1'b1, 1'b1, W'($urandom), 0, 0);
        run_job(1'b1, 1'b0, W'($urandom), 0, 0);
        run_job(1'b1, 1'b1, W'($urandom), 0, 2);
        run_job(1'b1, 1'b1, W'($urandom), 1, 0);

        s_req0_valid = 1'b1;
        s_req0_angle = 8'h5A;
        s_core_x = W'($urandom);
        #1;
        chk("s_grant", 32'(s_req0_ready), 32'(1));
        @(posedge clk);
        #1;
        s_req0_valid = 1'b0;
        t = 0;
        n = 0;
        while (t < 20) begin
            @(negedge clk);
            t++;
            s_core_x = W'($urandom);
            sx[t] = s_core_x;
            #1;
            if (s_core_en) n++;
            if (s_rsp_valid) break;
        end
        chk("s_latency", 32'(t), 32'(4));
        chk("s_n_en", 32'(n), 32'(1));
        chk("s_rsp_x", 32'(s_rsp_x), 32'(sx[3]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
